// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO: FSM encoding and character constants.
package uart_pkg;

    // Replay FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PULSE,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_e;

    localparam logic [7:0]  CHAR_CR         = 8'h0D;
    localparam logic [7:0]  CHAR_LF         = 8'h0A;
    localparam int unsigned WAIT_HI_TIMEOUT = 8;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x 8 register array: synchronous write, combinational read.
module fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between UART receiver and transmitter. Captures bytes on the
// falling edge of rx_int and replays them one at a time as tx_int strobes.
// Optional build macro UART_FIFO_CRLF_EN: append 8'h0A after every stored 8'h0D.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned TX_PULSE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_int,
    input  logic          tx_busy,
    output logic [7:0]    tx_data,
    output logic          tx_int,
    output logic [AW:0]   fifo_count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic          rx_r1_q, rx_r2_q;
    logic [7:0]    hold_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_d;
    logic          overflow_d;
    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tx_int_d;
    logic [7:0]    tx_data_d;

    logic          push_rx;
    logic          pop;
    logic          full;
    logic          wr_req;
    logic          wr_en;
    logic [7:0]    wr_byte;
    logic [7:0]    rd_data;

    // Edge detect on rx_int; hold reg grabs rx_data right at the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r1_q <= 1'b0;
            rx_r2_q <= 1'b0;
            hold_q  <= 8'h00;
        end else begin
            rx_r1_q <= rx_int;
            rx_r2_q <= rx_r1_q;
            if (rx_r1_q && !rx_int) begin
                hold_q <= rx_data;
            end
        end
    end

    assign push_rx = rx_r2_q & ~rx_r1_q;
    assign pop     = (state_q == ST_LOAD);
    assign full    = (fifo_count == FULL_COUNT);

`ifdef UART_FIFO_CRLF_EN
    logic crlf_pend_q, crlf_pend_d;

    // A real push wins the slot; the pending LF goes in on the first free cycle
    always_comb begin
        wr_req  = push_rx | crlf_pend_q;
        wr_byte = push_rx ? hold_q : CHAR_LF;
        if (push_rx) begin
            crlf_pend_d = crlf_pend_q | (wr_en && (hold_q == CHAR_CR));
        end else begin
            crlf_pend_d = 1'b0;
        end
    end

    // Pending line-feed insert flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crlf_pend_q <= 1'b0;
        end else begin
            crlf_pend_q <= crlf_pend_d;
        end
    end
`else
    assign wr_req  = push_rx;
    assign wr_byte = hold_q;
`endif

    // Push/pop bookkeeping; a push into a full FIFO is accepted only alongside a pop
    always_comb begin
        wr_en      = wr_req & (~full | pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow | (wr_req & full & ~pop);
        count_d    = fifo_count;
        if (wr_en && !pop) begin
            count_d = fifo_count + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = fifo_count - (AW+1)'(1);
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_count <= count_d;
            overflow   <= overflow_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_byte),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Replay FSM next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_int_d  = tx_int;
        tx_data_d = tx_data;
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0 && !tx_busy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d = rd_data;
                tx_int_d  = 1'b1;
                cnt_d     = 8'd0;
                state_d   = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == 8'(TX_PULSE - 1)) begin
                    tx_int_d = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = ST_WAIT_HI;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_HI: begin
                // No busy response: treat the byte as sent rather than stall forever
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == 8'(WAIT_HI_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, pulse/timeout counter and transmitter-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            tx_int  <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_int  <= tx_int_d;
            tx_data <= tx_data_d;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver and the UART transmitter in the loopback/display path.
- Captures each byte completed by the receiver: the falling edge of rx_int marks the byte, and rx_data is sampled at that edge.
- Stores bytes in a circular FIFO.
- Replays them one at a time to the transmitter using the same rx_int-style strobe the transmitter already consumes. This lets back-to-back received bytes survive while the transmitter is busy.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, 4, address width, log2(DEPTH).
- TX_PULSE, 4, clk cycles that tx_int is held high per replayed byte; minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from the receiver, stable at rx_int falling edge
- rx_int  in  1  receiver busy flag, high during reception; falling edge = byte complete
- tx_busy  in  1  transmitter bit-clock enable (its bps_start); high while a byte is being sent
- tx_data  out  8  byte presented to the transmitter
- tx_int  out  1  transmit strobe; transmitter starts on its falling edge
- fifo_count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n low): wr_ptr=0, rd_ptr=0, fifo_count=0, tx_data=8'h00, tx_int=0, overflow=0, FSM=IDLE, internal rx_int delay regs=0.
  - Asserting reset mid-operation aborts any pulse in progress; tx_int drops to 0 immediately.
- Write detect:
  - rx_int registered twice (r1, r2); push = r2 & ~r1. This is one cycle, two clocks after the actual edge.
  - rx_data is latched into the holding reg when r1 & ~rx_int, so data is captured at the edge.
- Push:
  - If count<DEPTH: mem[wr_ptr]<=hold, wr_ptr+1 (wraps modulo DEPTH), count+1.
  - If count==DEPTH and no pop in the same cycle: byte dropped, overflow<=1 (cleared only by reset).
- Pop: occurs only in state LOAD. mem[rd_ptr]→tx_data, rd_ptr+1 (wraps), count-1.
- Simultaneous push and pop: both take effect, count unchanged; a push while full with a concurrent pop is accepted.
- FSM:
  - IDLE: if count!=0 and tx_busy==0 → LOAD.
  - LOAD (1 cycle): pop → PULSE; tx_int<=1 on entry.
  - PULSE: hold tx_int=1 for TX_PULSE cycles, then tx_int<=0 → WAIT_HI.
  - WAIT_HI: wait for tx_busy==1 → WAIT_LO. If tx_busy does not rise within 8 cycles, go → IDLE (byte considered sent; no retry).
  - WAIT_LO: wait for tx_busy==0 → IDLE.
- Latency: byte in an empty FIFO with an idle transmitter → tx_int rises 4 clk after the rx_int falling edge (2 sync + IDLE + LOAD).
- Order: strictly FIFO; no reordering and no duplication.
- Empty: IDLE never leaves while count==0; tx_data holds the last popped value.
- Width: fifo_count is AW+1 bits, so the full state (DEPTH) is representable; pointers are AW bits and wrap naturally.

Optional Feature:
- Macro UART_FIFO_CRLF_EN.
- Defined: when a pushed byte equals 8'h0D, the cycle after the push an extra 8'h0A is pushed if space remains. If no space, the extra byte is dropped and overflow is set. A real push arriving that same following cycle takes priority; the 0A is inserted one cycle later (one pending-insert flag).
- Undefined: bytes are stored verbatim; no insert logic is present.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants ST_IDLE, ST_LOAD, ST_PULSE, ST_WAIT_HI, ST_WAIT_LO
  - constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, WAIT_HI_TIMEOUT=8
- One natural sub-module: fifo_mem, a DEPTH×8 register array with synchronous write and a combinational read at rd_ptr. The pointers, count and FSM stay in uart_rx_fifo.

Test Plan:
- Single byte: drive rx_int high 20 cycles, rx_data=8'h41, then drop rx_int → tx_int rises 4 clk later with tx_data=8'h41 and stays high 4 clk; fifo_count returns to 0.
- Burst with busy transmitter: hold tx_busy=1, push 8'h01..8'h05 → fifo_count=5, tx_int stays 0. Release tx_busy and model the transmitter → tx_data sequence 01,02,03,04,05 in order.
- Overflow: tx_busy=1, push 17 bytes 8'h10..8'h20 → fifo_count=16, overflow=1, byte 8'h20 absent; drain order is 10..1F.
- Wrap-around: push and drain 40 bytes one at a time → pointers wrap twice; every byte is returned unchanged and count never exceeds 1.
- Reset mid-pulse: assert rst_n=0 while tx_int=1 → tx_int=0, fifo_count=0 and overflow=0 asynchronously; after release, a new byte 8'h55 is replayed normally.
- CRLF (UART_FIFO_CRLF_EN defined): push 8'h0D → fifo_count=2, drain order 0D,0A. Undefined: fifo_count=1, drain 0D only.
